// File: rtl/serdes_range_sched_if.sv
// Bundle of the per-channel range-FIFO side and the merged output stream of
// serdes_range_sched. The scheduler uses the slave modport, the environment the master.
interface serdes_range_sched_if;
   logic [3:0]  I_frame_rdy;
   logic [3:0]  I_fifo_empty;
   logic [51:0] I_fifo_data;
   logic [3:0]  O_fifo_rd_en;
   logic [15:0] O_out_data;
   logic        O_out_en;
   logic        O_out_sof;
   logic        O_out_eof;
   logic        O_busy;

   modport master (
      output I_frame_rdy, I_fifo_empty, I_fifo_data,
      input  O_fifo_rd_en, O_out_data, O_out_en, O_out_sof, O_out_eof, O_busy
   );

   modport slave (
      input  I_frame_rdy, I_fifo_empty, I_fifo_data,
      output O_fifo_rd_en, O_out_data, O_out_en, O_out_sof, O_out_eof, O_busy
   );
endinterface

// File: rtl/serdes_range_sched.sv
// Round-robin frame scheduler: drains one complete frame at a time from four range
// FIFOs into a single stream framed by a header word and a word-count trailer.
module serdes_range_sched #(
   parameter logic [12:0] P_MAX_LEN = 13'd1024,
   parameter logic [11:0] P_HDR_TAG = 12'hEB9,
   parameter int unsigned P_GAP     = 4
) (
   input  logic                 I_sys_clk,
   input  logic                 I_sys_rst_n,
   serdes_range_sched_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HDR   = 3'd1,
      S_READ  = 3'd2,
      S_DRAIN = 3'd3,
      S_TRL   = 3'd4,
      S_GAP   = 3'd5
   } state_t;

   localparam logic [3:0] GAP_LAST = 4'(P_GAP - 1);

   state_t      state_q, state_d;
   logic [3:0]  pend_q, pend_d;
   logic [1:0]  ch_q, ch_d;
   logic [1:0]  last_q, last_d;
   logic [12:0] cnt_q, cnt_d;
   logic [3:0]  tmr_q, tmr_d;
   logic        rd_pipe_q, rd_pipe_d;
   logic [15:0] out_data_q, out_data_d;
   logic        out_en_q, out_en_d;
   logic        sof_q, sof_d;
   logic        eof_q, eof_d;

   logic [3:0]  rd_en_s;
   logic [3:0]  grant_s;
   logic [2:0]  pick_s;
   logic [12:0] fifo_word_s;

   // Returns {found, channel}: first set bit of pend searching from last+1 (mod 4).
   function automatic logic [2:0] rr_pick(input logic [3:0] pend, input logic [1:0] last);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int i = 4; i >= 1; i--) begin
         idx = last + 2'(i);
         if (pend[idx]) begin
            res = {1'b1, idx};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   // Data word of the channel being served.
   always_comb begin
      case (ch_q)
         2'd0:    fifo_word_s = bus.I_fifo_data[12:0];
         2'd1:    fifo_word_s = bus.I_fifo_data[25:13];
         2'd2:    fifo_word_s = bus.I_fifo_data[38:26];
         2'd3:    fifo_word_s = bus.I_fifo_data[51:39];
         default: fifo_word_s = 13'd0;
      endcase
   end

   // Next-state, read-enable and output-word decode.
   always_comb begin
      state_d    = state_q;
      pend_d     = pend_q;
      ch_d       = ch_q;
      last_d     = last_q;
      cnt_d      = cnt_q;
      tmr_d      = tmr_q;
      out_data_d = 16'h0000;
      out_en_d   = 1'b0;
      sof_d      = 1'b0;
      eof_d      = 1'b0;
      rd_en_s    = 4'b0000;
      rd_pipe_d  = 1'b0;
      grant_s    = 4'b0000;
      pick_s     = rr_pick(pend_q, last_q);

      // FIFO dout is valid the cycle after rd_en; registering it here lands the
      // word on the output exactly two cycles after the read.
      if (rd_pipe_q) begin
         out_data_d = {3'b000, fifo_word_s};
         out_en_d   = 1'b1;
      end else begin
         out_data_d = 16'h0000;
      end

      case (state_q)
         S_IDLE: begin
            if (pick_s[2]) begin
               grant_s[pick_s[1:0]] = 1'b1;
               ch_d       = pick_s[1:0];
               last_d     = pick_s[1:0];
               state_d    = S_HDR;
               out_data_d = {P_HDR_TAG, 2'b00, pick_s[1:0]};
               out_en_d   = 1'b1;
               sof_d      = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_HDR: begin
            cnt_d   = 13'd0;
            tmr_d   = 4'd0;
            state_d = S_READ;
         end
         S_READ: begin
            if (!bus.I_fifo_empty[ch_q] && (cnt_q < P_MAX_LEN)) begin
               rd_en_s[ch_q] = 1'b1;
               rd_pipe_d     = 1'b1;
               cnt_d         = cnt_q + 13'd1;
            end else begin
               tmr_d   = 4'd0;
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (tmr_q == 4'd1) begin
               state_d    = S_TRL;
               out_data_d = {3'b000, cnt_q};
               out_en_d   = 1'b1;
               eof_d      = 1'b1;
            end else begin
               tmr_d = tmr_q + 4'd1;
            end
         end
         S_TRL: begin
            tmr_d   = 4'd0;
            state_d = S_GAP;
         end
         S_GAP: begin
            if (tmr_q == GAP_LAST) begin
               state_d = S_IDLE;
            end else begin
               tmr_d = tmr_q + 4'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A new ready pulse outranks the clear from a same-cycle grant.
      pend_d = (pend_q & ~grant_s) | bus.I_frame_rdy;
   end

   // State and output registers.
   always_ff @(posedge I_sys_clk or negedge I_sys_rst_n) begin
      if (!I_sys_rst_n) begin
         state_q    <= S_IDLE;
         pend_q     <= 4'b0000;
         ch_q       <= 2'd0;
         last_q     <= 2'd3;
         cnt_q      <= 13'd0;
         tmr_q      <= 4'd0;
         rd_pipe_q  <= 1'b0;
         out_data_q <= 16'h0000;
         out_en_q   <= 1'b0;
         sof_q      <= 1'b0;
         eof_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pend_q     <= pend_d;
         ch_q       <= ch_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
         tmr_q      <= tmr_d;
         rd_pipe_q  <= rd_pipe_d;
         out_data_q <= out_data_d;
         out_en_q   <= out_en_d;
         sof_q      <= sof_d;
         eof_q      <= eof_d;
      end
   end

   assign bus.O_fifo_rd_en = rd_en_s;
   assign bus.O_out_data   = out_data_q;
   assign bus.O_out_en     = out_en_q;
   assign bus.O_out_sof    = sof_q;
   assign bus.O_out_eof    = eof_q;
   assign bus.O_busy       = (state_q != S_IDLE);

endmodule
